// File: rtl/apb_to_ahb_bridge.sv
// APB slave to AHB-Lite master bridge: each APB access becomes one AHB SINGLE word transfer.
// Optional watchdog on a stalled AHB slave is enabled by defining APB2AHB_TIMEOUT_EN.
module apb_to_ahb_bridge #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic                  o_pready,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pslverr,
    output logic                  o_hsel,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    output logic [2:0]            o_hsize,
    output logic [1:0]            o_htrans,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    output logic                  o_hwrite,
    input  logic [DATA_WIDTH-1:0] i_hrdata,
    input  logic                  i_hready,
    input  logic                  i_hresp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]            state;
    logic                  err;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign o_hburst = 3'b000;
    assign o_hprot  = HPROT_VAL;
    assign o_hsize  = 3'($clog2(DATA_WIDTH / 8));

`ifdef APB2AHB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             timeout;

    // Fires on the last allowed cycle, so RESP is entered TIMEOUT_CYCLES edges after ADDR entry.
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            err       <= 1'b0;
            wdata_q   <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            o_prdata  <= '0;
            o_hsel    <= 1'b0;
            o_htrans  <= HTRANS_IDLE;
            o_haddr   <= '0;
            o_hwdata  <= '0;
            o_hwrite  <= 1'b0;
`ifdef APB2AHB_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Only a genuine setup phase starts a transfer; a stray enable is ignored.
                    if (i_psel && !i_penable) begin
                        o_haddr  <= i_paddr;
                        o_hwrite <= i_pwrite;
                        wdata_q  <= i_pwdata;
                        o_hsel   <= 1'b1;
                        o_htrans <= HTRANS_NONSEQ;
                        state    <= ST_ADDR;
`ifdef APB2AHB_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (i_hready) begin
                        o_htrans <= HTRANS_IDLE;
                        o_hsel   <= 1'b0;
                        o_hwdata <= wdata_q;
                        state    <= ST_DATA;
`ifdef APB2AHB_TIMEOUT_EN
                        cnt      <= cnt + 1'b1;
                    end else if (timeout) begin
                        o_htrans  <= HTRANS_IDLE;
                        o_hsel    <= 1'b0;
                        o_prdata  <= '0;
                        o_pslverr <= 1'b1;
                        o_pready  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt      <= cnt + 1'b1;
`endif
                    end
                end
                ST_DATA: begin
                    // Remember the first cycle of a two-cycle ERROR response.
                    if (i_hresp) begin
                        err <= 1'b1;
                    end
                    if (i_hready) begin
                        o_prdata  <= o_hwrite ? '0 : i_hrdata;
                        o_pslverr <= err | i_hresp;
                        o_pready  <= 1'b1;
                        state     <= ST_RESP;
`ifdef APB2AHB_TIMEOUT_EN
                    end else if (timeout) begin
                        o_htrans  <= HTRANS_IDLE;
                        o_hsel    <= 1'b0;
                        o_prdata  <= '0;
                        o_pslverr <= 1'b1;
                        o_pready  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt       <= cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    o_pready  <= 1'b0;
                    o_pslverr <= 1'b0;
                    err       <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Directed bench for apb_to_ahb_bridge; the AHB slave is driven step by step from the sequence.
// Covers both builds: with and without APB2AHB_TIMEOUT_EN.
module tb_apb_to_ahb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic          hwrite;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    int vectors;
    int miscompares;

    apb_to_ahb_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .HPROT_VAL     (4'b0011),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_psel   (psel),
        .i_penable(penable),
        .i_pwrite (pwrite),
        .i_paddr  (paddr),
        .i_pwdata (pwdata),
        .o_pready (pready),
        .o_prdata (prdata),
        .o_pslverr(pslverr),
        .o_hsel   (hsel),
        .o_haddr  (haddr),
        .o_hburst (hburst),
        .o_hprot  (hprot),
        .o_hsize  (hsize),
        .o_htrans (htrans),
        .o_hwdata (hwdata),
        .o_hwrite (hwrite),
        .i_hrdata (hrdata),
        .i_hready (hready),
        .i_hresp  (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_setup(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
    endtask

    task automatic apb_idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic early_ready;
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        hrdata  = '0;
        hready  = 1'b1;
        hresp   = 1'b0;

        // Reset state and constant AHB attributes.
        tick();
        tick();
        reset = 1'b0;
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check("rst_hsel", 64'(hsel), 64'd0);
        check("rst_htrans", 64'(htrans), 64'd0);
        check("rst_haddr", 64'(haddr), 64'd0);
        check("rst_hwdata", 64'(hwdata), 64'd0);
        check("rst_hwrite", 64'(hwrite), 64'd0);
        check("hburst", 64'(hburst), 64'd0);
        check("hprot", 64'(hprot), 64'h3);
        check("hsize", 64'(hsize), 64'd2);

        // Enable without a setup phase must not start a transfer.
        psel    = 1'b1;
        penable = 1'b1;
        tick();
        check("stray_en_htrans", 64'(htrans), 64'd0);
        apb_idle();
        tick();

        // 1: write 0xDEADBEEF to 0x10, zero wait states.
        apb_setup(1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        check("t1_htrans_nonseq", 64'(htrans), 64'h2);
        check("t1_hsel", 64'(hsel), 64'd1);
        check("t1_haddr", 64'(haddr), 64'h10);
        check("t1_hwrite", 64'(hwrite), 64'd1);
        penable = 1'b1;
        tick();
        check("t1_htrans_idle", 64'(htrans), 64'd0);
        check("t1_hsel_low", 64'(hsel), 64'd0);
        check("t1_hwdata", 64'(hwdata), 64'hDEADBEEF);
        check("t1_pready_early", 64'(pready), 64'd0);
        tick();
        check("t1_pready", 64'(pready), 64'd1);
        check("t1_pslverr", 64'(pslverr), 64'd0);
        apb_idle();
        tick();
        check("t1_pready_drop", 64'(pready), 64'd0);

        // 2: read 0x20 with two data-phase wait states.
        apb_setup(1'b0, 32'h20, '0);
        tick();
        check("t2_haddr", 64'(haddr), 64'h20);
        check("t2_hwrite", 64'(hwrite), 64'd0);
        penable = 1'b1;
        tick();
        hready = 1'b0;
        tick();
        check("t2_wait1", 64'(pready), 64'd0);
        tick();
        check("t2_wait2", 64'(pready), 64'd0);
        hready = 1'b1;
        hrdata = 32'h12345678;
        tick();
        check("t2_pready", 64'(pready), 64'd1);
        check("t2_prdata", 64'(prdata), 64'h12345678);
        check("t2_pslverr", 64'(pslverr), 64'd0);
        apb_idle();
        hrdata = '0;
        tick();
        check("t2_pready_drop", 64'(pready), 64'd0);

        // 3: read with a two-cycle AHB ERROR response.
        apb_setup(1'b0, 32'h30, '0);
        tick();
        penable = 1'b1;
        tick();
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        check("t3_wait", 64'(pready), 64'd0);
        hready = 1'b1;
        tick();
        check("t3_pready", 64'(pready), 64'd1);
        check("t3_pslverr", 64'(pslverr), 64'd1);
        check("t3_prdata", 64'(prdata), 64'd0);
        hresp = 1'b0;
        apb_idle();
        tick();
        check("t3_pready_drop", 64'(pready), 64'd0);
        check("t3_pslverr_drop", 64'(pslverr), 64'd0);

        // 4: back-to-back write then read, no APB idle cycle in between.
        apb_setup(1'b1, 32'h40, 32'hA5A50001);
        tick();
        check("t4w_htrans", 64'(htrans), 64'h2);
        check("t4w_haddr", 64'(haddr), 64'h40);
        penable = 1'b1;
        tick();
        check("t4w_hwdata", 64'(hwdata), 64'hA5A50001);
        tick();
        check("t4w_pready", 64'(pready), 64'd1);
        check("t4w_pslverr", 64'(pslverr), 64'd0);
        apb_setup(1'b0, 32'h44, '0);
        tick();
        check("t4_gap_htrans", 64'(htrans), 64'd0);
        check("t4_gap_pready", 64'(pready), 64'd0);
        tick();
        check("t4r_htrans", 64'(htrans), 64'h2);
        check("t4r_haddr", 64'(haddr), 64'h44);
        check("t4r_hwrite", 64'(hwrite), 64'd0);
        penable = 1'b1;
        hrdata  = 32'hCAFEF00D;
        tick();
        tick();
        check("t4r_pready", 64'(pready), 64'd1);
        check("t4r_prdata", 64'(prdata), 64'hCAFEF00D);
        apb_idle();
        hrdata = '0;
        tick();

        // 5: reset while the bridge sits in the data phase, then a normal write.
        apb_setup(1'b1, 32'h50, 32'h11112222);
        tick();
        penable = 1'b1;
        tick();
        hready = 1'b0;
        reset  = 1'b1;
        tick();
        check("t5_htrans", 64'(htrans), 64'd0);
        check("t5_pready", 64'(pready), 64'd0);
        check("t5_hsel", 64'(hsel), 64'd0);
        check("t5_haddr", 64'(haddr), 64'd0);
        reset  = 1'b0;
        hready = 1'b1;
        apb_idle();
        tick();
        apb_setup(1'b1, 32'h60, 32'h33334444);
        tick();
        check("t5_post_haddr", 64'(haddr), 64'h60);
        check("t5_post_htrans", 64'(htrans), 64'h2);
        penable = 1'b1;
        tick();
        check("t5_post_hwdata", 64'(hwdata), 64'h33334444);
        tick();
        check("t5_post_pready", 64'(pready), 64'd1);
        check("t5_post_pslverr", 64'(pslverr), 64'd0);
        apb_idle();
        tick();

        // 6: AHB slave stuck with hready low.
        apb_setup(1'b1, 32'h70, 32'h55AA55AA);
        hready = 1'b0;
        tick();
        penable     = 1'b1;
        early_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (pready) early_ready = 1'b1;
        end
        check("t6_no_early_pready", 64'(early_ready), 64'd0);
        tick();
`ifdef APB2AHB_TIMEOUT_EN
        check("t6_to_pready", 64'(pready), 64'd1);
        check("t6_to_pslverr", 64'(pslverr), 64'd1);
        check("t6_to_prdata", 64'(prdata), 64'd0);
        check("t6_to_htrans", 64'(htrans), 64'd0);
        check("t6_to_hsel", 64'(hsel), 64'd0);
        apb_idle();
        tick();
        check("t6_to_pready_drop", 64'(pready), 64'd0);
        check("t6_to_pslverr_drop", 64'(pslverr), 64'd0);
`else
        check("t6_stall_pready", 64'(pready), 64'd0);
        check("t6_stall_htrans", 64'(htrans), 64'h2);
        early_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pready) early_ready = 1'b1;
        end
        check("t6_stall_long", 64'(early_ready), 64'd0);
        reset = 1'b1;
        apb_idle();
        tick();
        reset = 1'b0;
        check("t6_recover_htrans", 64'(htrans), 64'd0);
`endif
        hready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
